linescanner_line_packer: RTL

//  Consumes the 8-bit pixel stream (pixel_data / pixel_captured) produced by the linescanner capture unit.

---
 rtl/linescanner_line_packer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/linescanner_line_packer.sv
// linescanner_line_packer: packs the 8-bit capture stream four pixels per word into a FIFO-backed valid/ready stream.
// Each line is admitted whole or refused, so a line that has started can never overflow the FIFO.
module linescanner_line_packer #(
    parameter int LINE_PIXELS      = 1024,
    parameter int FIFO_DEPTH_WORDS = 512,
    parameter int CNT_W            = 16
) (
    input  logic                               pixel_clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [7:0]                         pixel_data,
    input  logic                               pixel_captured,
    output logic [31:0]                        m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               m_last,
    output logic [CNT_W-1:0]                   line_count,
    output logic [CNT_W-1:0]                   lines_dropped,
    output logic [$clog2(LINE_PIXELS+1)-1:0]   last_line_length,
    output logic                               line_truncated,
    output logic                               busy
);
    localparam int LEN_W = $clog2(LINE_PIXELS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH_WORDS);
    localparam int OCC_W = $clog2(FIFO_DEPTH_WORDS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(LINE_PIXELS);
    localparam logic [OCC_W-1:0] WPL      = OCC_W'((LINE_PIXELS + 3) / 4);
    localparam logic [OCC_W-1:0] DEPTH    = OCC_W'(FIFO_DEPTH_WORDS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH_WORDS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} state_t;

    state_t             state, state_next;
    logic               lval_d;
    logic [LEN_W-1:0]   pix_cnt;
    logic [23:0]        pack;
    logic [31:0]        stage;
    logic               stage_valid;
    logic               line_end;
    logic               wr_en;
    logic [32:0]        wr_word;
    logic [32:0]        mem [FIFO_DEPTH_WORDS];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               rd_en;

    wire                line_start = pixel_captured && !lval_d;
    wire                admit      = enable && (DEPTH - occ) >= WPL;
    wire [1:0]          lane       = pix_cnt[1:0];

    assign rd_en = occ != '0 && (!m_valid || m_ready);
    assign busy  = state != IDLE || occ != '0;

    always_comb begin
        state_next = state;
        line_end   = 1'b0;
        wr_en      = 1'b0;
        wr_word    = {1'b0, stage};
        case (state)
            IDLE:    state_next = line_start ? (admit ? CAPTURE : DISCARD) : IDLE;
            CAPTURE: begin
                line_end   = !pixel_captured || pix_cnt == MAX_LEN;
                wr_en      = stage_valid || line_end;
                wr_word    = {line_end, stage_valid ? stage : {8'h00, pack}};
                state_next = line_end ? (pixel_captured ? DISCARD : IDLE) : CAPTURE;
            end
            DISCARD: state_next = pixel_captured ? DISCARD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state            <= IDLE;
            lval_d           <= 1'b1;
            pix_cnt          <= '0;
            pack             <= '0;
            stage            <= '0;
            stage_valid      <= 1'b0;
            line_count       <= '0;
            lines_dropped    <= '0;
            last_line_length <= '0;
            line_truncated   <= 1'b0;
        end else begin
            state          <= state_next;
            lval_d         <= pixel_captured;
            line_truncated <= line_end && pixel_captured;
            if (state == IDLE && line_start && enable && !admit)
                lines_dropped <= lines_dropped + CNT_W'(1);
            // IDLE preloads pixel 0 every cycle; it only matters on the admitting edge
            if (state == IDLE) begin
                pix_cnt     <= LEN_W'(1);
                pack        <= {16'h0000, pixel_data};
                stage_valid <= 1'b0;
            end else if (state == CAPTURE && line_end) begin
                line_count       <= line_count + CNT_W'(1);
                last_line_length <= pix_cnt;
                stage_valid      <= 1'b0;
            end else if (state == CAPTURE) begin
                pix_cnt     <= pix_cnt + LEN_W'(1);
                stage_valid <= lane == 2'd3;
                if (lane == 2'd3)
                    stage <= {pixel_data, pack};
                pack <= lane == 2'd3 ? 24'h0 : {lane == 2'd2 ? pixel_data : pack[23:16],
                                                lane == 2'd1 ? pixel_data : pack[15:8],
                                                lane == 2'd0 ? pixel_data : pack[7:0]};
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr == PTR_LAST ? '0 : wr_ptr + PTR_W'(1);
            if (rd_en) begin
                rd_ptr           <= rd_ptr == PTR_LAST ? '0 : rd_ptr + PTR_W'(1);
                {m_last, m_data} <= mem[rd_ptr];
            end
            occ     <= occ + OCC_W'(wr_en) - OCC_W'(rd_en);
            m_valid <= rd_en || (m_valid && !m_ready);
        end
    end
endmodule
